// File: rtl/wave_capture_if.sv
// Sample-stream and RAM-write bundle between the audio front end, wave_capture
// and the waveform display's double-buffered sample RAM.
interface wave_capture_if #(
  parameter int SAMPLE_W = 16
) ();
  logic                new_sample_ready;
  logic [SAMPLE_W-1:0] new_sample_in;
  logic                wave_display_idle;
  logic [8:0]          write_address;
  logic                write_enable;
  logic [7:0]          write_sample;
  logic                read_index;

  modport master (
    output new_sample_ready, new_sample_in, wave_display_idle,
    input  write_address, write_enable, write_sample, read_index
  );

  modport slave (
    input  new_sample_ready, new_sample_in, wave_display_idle,
    output write_address, write_enable, write_sample, read_index
  );
endinterface

// File: rtl/wave_capture.sv
// Captures 256 offset-binary samples after a positive-going zero crossing into
// the idle RAM half, then swaps halves once the display is idle.
// Optional forced trigger on a quiet input: define WAVE_CAPTURE_TIMEOUT_EN.
//
// state  | meaning
// ARMED  | waiting for a positive-going zero crossing (or timeout)
// ACTIVE | writing samples 1..255 of the capture
// WAIT   | capture complete, waiting for the display to go idle to swap
module wave_capture #(
  parameter int SAMPLE_W        = 16,
  parameter int TIMEOUT_SAMPLES = 1024
) (
  input  logic           clk,
  input  logic           reset,
  wave_capture_if.slave  bus
);

  if (SAMPLE_W < 9 || TIMEOUT_SAMPLES < 1) begin : g_param_check
    $error("wave_capture: SAMPLE_W must be >= 9 and TIMEOUT_SAMPLES >= 1");
  end

  typedef enum logic [1:0] {
    S_ARMED  = 2'd0,
    S_ACTIVE = 2'd1,
    S_WAIT   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic        write_index_q, write_index_d;
  logic        prev_sign_q, prev_sign_d;
  logic        we_q, we_d;
  logic [8:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;

  logic        sample_sign;
  logic        crossing;
  logic        forced;
  logic        trigger;
  logic [7:0]  sample_off;
  logic        unused_low_bits;

  assign sample_sign     = bus.new_sample_in[SAMPLE_W-1];
  assign sample_off      = {~sample_sign, bus.new_sample_in[SAMPLE_W-2 -: 7]};
  assign unused_low_bits = ^bus.new_sample_in[SAMPLE_W-9:0];
  assign crossing        = bus.new_sample_ready && prev_sign_q && !sample_sign;
  assign trigger         = crossing || forced;

`ifdef WAVE_CAPTURE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_SAMPLES) + 1;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counter saturates at TIMEOUT_SAMPLES; the strobe after that forces a trigger.
  assign forced = bus.new_sample_ready && (state_q == S_ARMED) &&
                  (to_cnt_q == TO_W'(TIMEOUT_SAMPLES));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q != S_ARMED || state_d != S_ARMED) begin
      to_cnt_d = '0;
    end else if (bus.new_sample_ready) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign forced = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_ARMED;
      count_q       <= '0;
      write_index_q <= 1'b0;
      prev_sign_q   <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      write_index_q <= write_index_d;
      prev_sign_q   <= prev_sign_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    write_index_d = write_index_q;
    prev_sign_d   = bus.new_sample_ready ? sample_sign : prev_sign_q;
    case (state_q)
      S_ARMED: begin
        if (trigger) begin
          state_d = S_ACTIVE;
          count_d = 8'd1;
        end
      end
      S_ACTIVE: begin
        if (bus.new_sample_ready) begin
          count_d = count_q + 8'd1;
          if (count_q == 8'hFF) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A trigger coinciding with the swap is dropped; ARMED needs a fresh crossing.
        if (bus.wave_display_idle) begin
          write_index_d = ~write_index_q;
          state_d       = S_ARMED;
        end
      end
      default: begin
        state_d = S_ARMED;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    case (state_q)
      S_ARMED: begin
        if (trigger) begin
          we_d   = 1'b1;
          addr_d = {write_index_q, 8'h00};
          data_d = sample_off;
        end
      end
      S_ACTIVE: begin
        if (bus.new_sample_ready) begin
          we_d   = 1'b1;
          addr_d = {write_index_q, count_q};
          data_d = sample_off;
        end
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
  end

  assign bus.write_enable  = we_q;
  assign bus.write_address = addr_q;
  assign bus.write_sample  = data_q;
  assign bus.read_index    = ~write_index_q;

endmodule

// File: tb/tb_wave_capture.sv
// Randomized bench for wave_capture: the expected RAM write sequence is built from
// the capture rules (crossing, 256 in-order writes per half, swap on idle).
module tb_wave_capture;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wave_capture_if #(.SAMPLE_W(16)) bus ();

  wave_capture #(.SAMPLE_W(16), .TIMEOUT_SAMPLES(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Each entry is {address[8:0], sample[7:0]}
  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.write_enable === 1'b1) got_q.push_back({bus.write_address, bus.write_sample});
  end

  // Offset binary = signed top byte + 128.
  function automatic logic [7:0] offset8(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    return 8'((s >>> 8) + 128);
  endfunction

  function automatic logic [15:0] rand_neg();
    return 16'($urandom_range(32'h8000, 32'hFFFF));
  endfunction

  function automatic logic [15:0] rand_pos();
    return 16'($urandom_range(0, 32'h7FFF));
  endfunction

  task automatic strobe(input logic [15:0] v);
    bus.new_sample_ready = 1'b1;
    bus.new_sample_in    = v;
    @(negedge clk);
    bus.new_sample_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.new_sample_ready  = 1'b0;
    bus.wave_display_idle = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic swap_pulse();
    bus.wave_display_idle = 1'b1;
    @(negedge clk);
    bus.wave_display_idle = 1'b0;
    #1;
  endtask

  task automatic run_crossing(input logic half);
    logic [15:0] p;
    p = rand_pos();
    strobe(rand_neg());
    strobe(p);
    exp_q.push_back({half, 8'h00, offset8(p)});
  endtask

  // Samples first..last of a capture with random gaps and random (ignored) display-idle.
  task automatic run_body(input logic half, input int first, input int last,
                          input bit rnd, input logic [15:0] val);
    logic [15:0] v;
    for (int i = first; i <= last; i++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.wave_display_idle = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      bus.wave_display_idle = (i == 255) ? 1'b0 : 1'($urandom_range(0, 1));
      v = rnd ? 16'($urandom) : val;
      strobe(v);
      exp_q.push_back({half, 8'(i), offset8(v)});
    end
    bus.wave_display_idle = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (bus.write_enable !== 1'b0) begin
      failures++; $display("FAIL reset_we got=%b exp=0", bus.write_enable);
    end
    checks++;
    if (bus.write_address !== 9'h000) begin
      failures++; $display("FAIL reset_addr got=%h exp=000", bus.write_address);
    end
    checks++;
    if (bus.write_sample !== 8'h00) begin
      failures++; $display("FAIL reset_sample got=%h exp=00", bus.write_sample);
    end
    checks++;
    if (bus.read_index !== 1'b1) begin
      failures++; $display("FAIL reset_read_index got=%b exp=1", bus.read_index);
    end
  endtask

  task automatic test_first_capture();
    do_reset();
    strobe(16'hF000);
    strobe(16'h0100);
    #1;
    checks++;
    if ({bus.write_enable, bus.write_address, bus.write_sample} !== {1'b1, 9'h000, 8'h81}) begin
      failures++;
      $display("FAIL first_write got we=%b addr=%h data=%h exp we=1 addr=000 data=81",
               bus.write_enable, bus.write_address, bus.write_sample);
    end
    exp_q.push_back({9'h000, 8'h81});
    run_body(1'b0, 1, 255, 1'b0, 16'h1234);
    // In WAIT with the display busy: crossings must not write or swap.
    for (int k = 0; k < 6; k++) begin
      strobe(rand_neg());
      strobe(rand_pos());
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL cap1_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL cap1_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (bus.read_index !== 1'b1) begin
      failures++; $display("FAIL wait_hold_read_index got=%b exp=1", bus.read_index);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_swap();
    swap_pulse();
    checks++;
    if (bus.read_index !== 1'b0) begin
      failures++; $display("FAIL swap_read_index got=%b exp=0", bus.read_index);
    end
    run_crossing(1'b1);
    run_body(1'b1, 1, 255, 1'b1, 16'h0);
    #1;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL cap2_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL cap2_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (bus.read_index !== 1'b0) begin
      failures++; $display("FAIL cap2_read_index got=%b exp=0", bus.read_index);
    end
    got_q.delete(); exp_q.delete();
    swap_pulse();
    checks++;
    if (bus.read_index !== 1'b1) begin
      failures++; $display("FAIL swap_back_read_index got=%b exp=1", bus.read_index);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 2000; i++) begin
      strobe(16'h4000);
      if (i == 1024) begin
        #1;
        checks++;
        if (got_q.size() != 0) begin
          failures++; $display("FAIL dc_early_write got=%0d writes exp=0", got_q.size());
        end
      end
`ifdef WAVE_CAPTURE_TIMEOUT_EN
      if (i == 1025) begin
        #1;
        checks++;
        if (got_q.size() != 1) begin
          failures++; $display("FAIL timeout_count got=%0d exp=1", got_q.size());
        end else begin
          checks++;
          if (got_q[0] !== {9'h000, 8'hC0}) begin
            failures++; $display("FAIL timeout_write got=%h exp=000c0", got_q[0]);
          end
        end
        break;
      end
`endif
    end
`ifndef WAVE_CAPTURE_TIMEOUT_EN
    #1;
    checks++;
    if (got_q.size() != 0) begin
      failures++; $display("FAIL dc_no_write got=%0d writes exp=0", got_q.size());
    end
`endif
    do_reset();
  endtask

  task automatic test_reset_mid_active();
    do_reset();
    run_crossing(1'b0);
    run_body(1'b0, 1, 255, 1'b1, 16'h0);
    got_q.delete(); exp_q.delete();
    swap_pulse();
    run_crossing(1'b1);
    run_body(1'b1, 1, 99, 1'b1, 16'h0);
    #1;
    checks++;
    if (got_q.size() != 100) begin
      failures++; $display("FAIL partial_count got=%0d exp=100", got_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL partial_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.write_enable !== 1'b0 || bus.read_index !== 1'b1) begin
      failures++;
      $display("FAIL abort_state got we=%b ri=%b exp we=0 ri=1", bus.write_enable, bus.read_index);
    end
    got_q.delete(); exp_q.delete();
    run_crossing(1'b0);
    run_body(1'b0, 1, 255, 1'b1, 16'h0);
    #1;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL restart_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL restart_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  // Entered in WAIT with write_index=0 (read_index=1).
  task automatic test_swap_with_crossing();
    strobe(rand_neg());
    bus.wave_display_idle = 1'b1;
    bus.new_sample_ready  = 1'b1;
    bus.new_sample_in     = rand_pos();
    @(negedge clk);
    bus.wave_display_idle = 1'b0;
    bus.new_sample_ready  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.read_index !== 1'b0) begin
      failures++; $display("FAIL coincident_swap got=%b exp=0", bus.read_index);
    end
    checks++;
    if (got_q.size() != 0) begin
      failures++; $display("FAIL coincident_no_write got=%0d writes exp=0", got_q.size());
    end
    got_q.delete();
    run_crossing(1'b1);
    run_body(1'b1, 1, 255, 1'b1, 16'h0);
    #1;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL after_coincident_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL after_coincident_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    reset                 = 1'b1;
    bus.new_sample_ready  = 1'b0;
    bus.new_sample_in     = '0;
    bus.wave_display_idle = 1'b0;
    test_reset();
    test_first_capture();
    test_swap();
    test_timeout();
    test_reset_mid_active();
    test_swap_with_crossing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Writer side of the double-buffered 512-entry sample RAM that the waveform display reads.
- Watches the audio sample stream and arms on a positive-going zero crossing.
- Writes 256 consecutive 8-bit offset-binary samples into the half-buffer not being displayed.
- Waits for the display to go idle, then swaps halves through read_index.

Parameters:
- SAMPLE_W, 16, width of the signed two's-complement input sample.
- TIMEOUT_SAMPLES, 1024, sample count before forced trigger; used only when WAVE_CAPTURE_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- new_sample_ready  input  1  one-cycle strobe; new_sample_in is valid this cycle
- new_sample_in  input  SAMPLE_W  signed audio sample
- wave_display_idle  input  1  high while the display is outside its active region (safe to swap)
- write_address  output  9  RAM write address {write_index, count[7:0]}
- write_enable  output  1  RAM write strobe
- write_sample  output  8  offset-binary sample: {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2:SAMPLE_W-8]}
- read_index  output  1  half the display reads; always ~write_index

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - state=ARMED, count=0, write_index=0 (so read_index=1), prev_sign=0.
  - write_enable=0, write_address=0, write_sample=0.
- prev_sign updates to new_sample_in[SAMPLE_W-1] on every new_sample_ready, in all states.
- Trigger condition: new_sample_ready && prev_sign==1 && new_sample_in[SAMPLE_W-1]==0. Zero counts as non-negative.
- All outputs are registered. A qualifying sample in cycle N produces write_enable=1 with its address and data in cycle N+1. write_enable is 0 in every other cycle.
- ARMED:
  - On trigger: write the triggering sample at count 0, set count=1, go to ACTIVE.
  - wave_display_idle is ignored.
- ACTIVE:
  - Each new_sample_ready writes the sample at the current count, then count++.
  - The write at count 255 moves to WAIT, and count wraps to 0.
  - Zero crossings are ignored.
  - Exactly 256 writes happen per capture, to addresses {write_index,8'h00} through {write_index,8'hFF}, strictly in order.
- WAIT:
  - Samples are not written (prev_sign still tracks).
  - When wave_display_idle==1: toggle write_index (read_index toggles the same cycle), go to ARMED.
  - If the toggle cycle also has a triggering sample, the trigger is ignored; the next crossing is needed.
- Reset mid-ACTIVE: capture is aborted and write_index returns to 0. The partially written half is not marked complete.
- read_index changes only on the WAIT->ARMED transition, never mid-capture.

Optional Feature:
- Macro: WAVE_CAPTURE_TIMEOUT_EN.
- Defined:
  - A timeout counter, clog2(TIMEOUT_SAMPLES)+1 bits, counts new_sample_ready strobes while in ARMED. It clears on entry to ARMED and on reset.
  - When it reaches TIMEOUT_SAMPLES, the next sample forces a trigger even without a zero crossing. This gives a flat/DC input a visible trace.
  - A genuine crossing on the same sample is a single trigger, not two.
- Not defined: no counter; ARMED waits indefinitely for a crossing.

Test Plan:
1. Reset, then samples 16'hF000, 16'h0100 (ready strobed) -> write_enable on the cycle after 16'h0100; write_address=9'h000, write_sample=8'h81; state ACTIVE; read_index=1.
2. Continue with 255 more samples of value 16'h1234 -> addresses 9'h001..9'h0FF, each with write_sample=8'h92; no write after 9'h0FF; wave_display_idle=0 holds WAIT and read_index stays 1.
3. In WAIT, assert wave_display_idle for one cycle -> read_index=0 next cycle; next crossing writes start at 9'h100 and end at 9'h1FF.
4. In ARMED, feed only positive samples (16'h4000) for 2000 strobes without the macro -> write_enable never asserts. With WAVE_CAPTURE_TIMEOUT_EN and TIMEOUT_SAMPLES=1024 -> the first write (address 9'h000, sample 8'hC0) comes from the 1025th strobe.
5. Assert reset after 100 writes in ACTIVE -> next cycle write_enable=0, read_index=1, state ARMED. The next crossing restarts writes at 9'h000.
6. Crossing sample coincident with wave_display_idle in WAIT -> swap occurs, no write. A following -/+ pair triggers a normal capture.
